wb_trace_capture: RTL and testbench

WB_TRACE_CAPTURE -- requirements
Module: wb_trace_capture

---
 rtl/wb_trace_pkg.sv | 24 ++
 rtl/wb_trace_mem.sv | 26 ++
 rtl/wb_trace_capture.sv | 143 ++++++++++++++
 tb/tb_wb_trace_capture.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_trace_pkg.sv
// Shared types and constants for the Wishbone trace capture block.
// Covers the capture state encoding and the layout of one trace entry.
package wb_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } trace_state_e;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_ARMED_ENC = 2'd1;
  localparam logic [1:0] ST_DONE_ENC  = 2'd2;

  localparam int DEF_ADR_W = 32;
  localparam int DEF_DAT_W = 32;
  // Entry layout is {we, adr, dat}, with we in the MSB.
  localparam int ENTRY_W   = 1 + DEF_ADR_W + DEF_DAT_W;

  function automatic int entry_width(input int adr_w, input int dat_w);
    return 1 + adr_w + dat_w;
  endfunction

endpackage

// File: rtl/wb_trace_mem.sv
// Trace storage: DEPTH words, one write port and one registered read port.
// A read and a write to the same address in one cycle return the old word.
module wb_trace_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 65
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/wb_trace_capture.sv
// Snoops a Wishbone slave port and records filtered transfers into a FIFO
// trace buffer, with stop-when-full or overwrite-oldest capture modes.
module wb_trace_capture
  import wb_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ADR_W = 32,
  parameter int DAT_W = 32
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_we_i,
  input  logic                   wbs_ack_o,
  input  logic [ADR_W-1:0]       wbs_adr_i,
  input  logic [DAT_W-1:0]       wbs_dat_i,
  input  logic [DAT_W-1:0]       wbs_dat_o,
  input  logic [ADR_W-1:0]       filt_base_i,
  input  logic [ADR_W-1:0]       filt_mask_i,
  input  logic                   arm_i,
  input  logic                   clear_i,
  input  logic                   wrap_i,
  input  logic                   rd_en_i,
  output logic                   rd_valid_o,
  output logic                   rd_we_o,
  output logic [ADR_W-1:0]       rd_adr_o,
  output logic [DAT_W-1:0]       rd_dat_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [1:0]             state_o,
  output logic                   overflow_o,
  output logic                   irq_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = entry_width(ADR_W, DAT_W);

  trace_state_e  state, state_nx;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nx;
  logic          overflow, irq, rd_valid;
  logic          hit, full, pop, store, drop_oldest, ovf_set, done_enter;
  logic [EW-1:0] wr_entry, rd_entry;

  assign hit  = wbs_cyc_i & wbs_stb_i & wbs_ack_o &
                ((wbs_adr_i & filt_mask_i) == (filt_base_i & filt_mask_i));
  assign full = (count == CW'(DEPTH));
  assign pop  = rd_en_i & (count != '0) & ~clear_i;
  assign wr_entry = {wbs_we_i, wbs_adr_i, wbs_we_i ? wbs_dat_i : wbs_dat_o};

  // A full buffer accepts a hit if a pop frees a slot this cycle; otherwise
  // only wrap mode stores, by discarding the oldest entry.
  always_comb begin
    store       = 1'b0;
    drop_oldest = 1'b0;
    ovf_set     = 1'b0;
    done_enter  = 1'b0;
    state_nx    = state;
    if (state == ST_ARMED && hit && !clear_i) begin
      if (!full || pop) begin
        store = 1'b1;
      end else if (wrap_i) begin
        store       = 1'b1;
        drop_oldest = 1'b1;
        ovf_set     = 1'b1;
      end
    end
    case ({store & ~drop_oldest, pop})
      2'b10:   count_nx = count + CW'(1);
      2'b01:   count_nx = count - CW'(1);
      default: count_nx = count;
    endcase
    case (state)
      ST_IDLE:  if (arm_i) state_nx = ST_ARMED;
      ST_ARMED: begin
        if (hit && !wrap_i && count_nx == CW'(DEPTH)) begin
          state_nx   = ST_DONE;
          done_enter = 1'b1;
        end
      end
      ST_DONE:  if (arm_i && !full) state_nx = ST_ARMED;
      default:  state_nx = ST_IDLE;
    endcase
    if (clear_i) begin
      state_nx   = ST_IDLE;
      done_enter = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      irq      <= 1'b0;
      rd_valid <= 1'b0;
    end else if (clear_i) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      irq      <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_nx;
      count    <= count_nx;
      if (store) wr_ptr <= wr_ptr + PW'(1);
      if (pop || drop_oldest) rd_ptr <= rd_ptr + PW'(1);
      overflow <= overflow | ovf_set;
      irq      <= done_enter | (ovf_set & ~overflow);
      rd_valid <= pop;
    end
  end

  wb_trace_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_mem (
    .clk   (wb_clk_i),
    .we    (store),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .re    (pop),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  // Read fields are held at zero outside the valid cycle so reset clears them
  // without needing a reset on the RAM read register.
  assign rd_valid_o = rd_valid;
  assign rd_we_o    = rd_valid ? rd_entry[EW-1] : 1'b0;
  assign rd_adr_o   = rd_valid ? rd_entry[EW-2 -: ADR_W] : '0;
  assign rd_dat_o   = rd_valid ? rd_entry[DAT_W-1:0] : '0;
  assign count_o    = count;
  assign state_o    = state;
  assign overflow_o = overflow;
  assign irq_o      = irq;

endmodule

// File: tb/tb_wb_trace_capture.sv
// Bench for wb_trace_capture: directed scenarios then random traffic, all
// checked against a queue-based reference model of the trace buffer.
module tb_wb_trace_capture;

  localparam int DEPTH = 16;
  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int EW    = 1 + ADR_W + DAT_W;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i;
  logic             wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_ack_o;
  logic [ADR_W-1:0] wbs_adr_i;
  logic [DAT_W-1:0] wbs_dat_i, wbs_dat_o;
  logic [ADR_W-1:0] filt_base_i, filt_mask_i;
  logic             arm_i, clear_i, wrap_i, rd_en_i;
  logic             rd_valid_o, rd_we_o;
  logic [ADR_W-1:0] rd_adr_o;
  logic [DAT_W-1:0] rd_dat_o;
  logic [CW-1:0]    count_o;
  logic [1:0]       state_o;
  logic             overflow_o, irq_o;

  // clock / reset
  always #5 wb_clk_i = ~wb_clk_i;

  wb_trace_capture #(.DEPTH(DEPTH), .ADR_W(ADR_W), .DAT_W(DAT_W)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_dat_o   (wbs_dat_o),
    .filt_base_i (filt_base_i),
    .filt_mask_i (filt_mask_i),
    .arm_i       (arm_i),
    .clear_i     (clear_i),
    .wrap_i      (wrap_i),
    .rd_en_i     (rd_en_i),
    .rd_valid_o  (rd_valid_o),
    .rd_we_o     (rd_we_o),
    .rd_adr_o    (rd_adr_o),
    .rd_dat_o    (rd_dat_o),
    .count_o     (count_o),
    .state_o     (state_o),
    .overflow_o  (overflow_o),
    .irq_o       (irq_o)
  );

  // scoreboard / reference model
  logic [EW-1:0] exp_q[$];
  int            m_state = 0;
  bit            m_ovf   = 1'b0;
  bit            m_irq   = 1'b0;
  bit            m_rdv   = 1'b0;
  logic [EW-1:0] m_rd    = '0;
  int            checks  = 0;
  int            errors  = 0;
  int            irq_seen = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_state = 0;
    m_ovf   = 1'b0;
    m_irq   = 1'b0;
    m_rdv   = 1'b0;
  endtask

  // Evaluate the edge about to happen from the inputs currently driven.
  task automatic model_step();
    bit            hit, pop;
    int            pre;
    logic [EW-1:0] e;
    pre = exp_q.size();
    if (clear_i) begin
      model_reset();
      return;
    end
    hit = wbs_cyc_i && wbs_stb_i && wbs_ack_o &&
          ((wbs_adr_i & filt_mask_i) == (filt_base_i & filt_mask_i));
    pop   = rd_en_i && (pre > 0);
    m_rdv = pop;
    m_irq = 1'b0;
    if (pop) m_rd = exp_q.pop_front();
    if (m_state == 1 && hit) begin
      e = {wbs_we_i, wbs_adr_i, wbs_we_i ? wbs_dat_i : wbs_dat_o};
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back(e);
      end else if (wrap_i) begin
        void'(exp_q.pop_front());
        exp_q.push_back(e);
        if (!m_ovf) begin
          m_ovf = 1'b1;
          m_irq = 1'b1;
        end
      end
      if (!wrap_i && exp_q.size() == DEPTH) begin
        m_state = 2;
        m_irq   = 1'b1;
      end
    end else if (m_state == 0 && arm_i) begin
      m_state = 1;
    end else if (m_state == 2 && arm_i && pre < DEPTH) begin
      m_state = 1;
    end
  endtask

  task automatic check_all();
    chk("state", 64'(state_o), 64'(m_state));
    chk("count", 64'(count_o), 64'(exp_q.size()));
    chk("overflow", 64'(overflow_o), 64'(m_ovf));
    chk("irq", 64'(irq_o), 64'(m_irq));
    chk("rd_valid", 64'(rd_valid_o), 64'(m_rdv));
    if (m_rdv) begin
      chk("rd_we", 64'(rd_we_o), 64'(m_rd[EW-1]));
      chk("rd_adr", 64'(rd_adr_o), 64'(m_rd[EW-2 -: ADR_W]));
      chk("rd_dat", 64'(rd_dat_o), 64'(m_rd[DAT_W-1:0]));
    end
    if (irq_o) irq_seen++;
  endtask

  // driver tasks
  task automatic tick();
    model_step();
    @(posedge wb_clk_i);
    #1;
    check_all();
  endtask

  task automatic bus(input bit on, input bit we, input logic [31:0] adr,
                     input logic [31:0] wd, input logic [31:0] rd);
    wbs_cyc_i = on;
    wbs_stb_i = on;
    wbs_ack_o = on;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = wd;
    wbs_dat_o = rd;
  endtask

  task automatic hit_cyc(input bit we, input logic [31:0] adr, input logic [31:0] d);
    bus(1'b1, we, adr, we ? d : 32'hdead_beef, we ? 32'hbad0_bad0 : d);
    tick();
    bus(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic pulse_arm();
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  initial begin
    wb_rst_i    = 1'b1;
    bus(1'b0, 1'b0, '0, '0, '0);
    filt_base_i = '0;
    filt_mask_i = '0;
    arm_i       = 1'b0;
    clear_i     = 1'b0;
    wrap_i      = 1'b0;
    rd_en_i     = 1'b0;
    repeat (2) @(posedge wb_clk_i);
    #1;
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_outs", 64'({rd_valid_o, rd_we_o, overflow_o, irq_o}), 64'd0);
    chk("rst_rd_fields", {rd_adr_o, rd_dat_o}, 64'd0);
    wb_rst_i = 1'b0;
    tick();

    // Three writes, mask 0, then three pops in order
    pulse_arm();
    for (int i = 0; i < 3; i++) hit_cyc(1'b1, 32'h3000_0000 + 32'(4 * i), 32'h11 * 32'(i + 1));
    chk("basic_count", 64'(count_o), 64'd3);
    for (int i = 0; i < 3; i++) begin
      rd_en_i = 1'b1;
      tick();
      rd_en_i = 1'b0;
      chk("basic_valid", 64'(rd_valid_o), 64'd1);
      chk("basic_we", 64'(rd_we_o), 64'd1);
      chk("basic_adr", 64'(rd_adr_o), 64'(32'h3000_0000 + 32'(4 * i)));
      chk("basic_dat", 64'(rd_dat_o), 64'(32'h11 * 32'(i + 1)));
      tick();
      chk("basic_valid_gap", 64'(rd_valid_o), 64'd0);
    end

    // Stop mode: 17 hits, DONE after the 16th
    do_clear();
    irq_seen = 0;
    pulse_arm();
    for (int i = 1; i <= 17; i++) hit_cyc(1'b1, 32'h4000_0000, 32'(i));
    chk("stop_state", 64'(state_o), 64'd2);
    chk("stop_count", 64'(count_o), 64'd16);
    chk("stop_irq_pulses", 64'(irq_seen), 64'd1);
    pulse_arm();
    chk("stop_rearm_full", 64'(state_o), 64'd2);

    // Wrap mode: 20 hits, oldest four overwritten
    do_clear();
    wrap_i   = 1'b1;
    irq_seen = 0;
    pulse_arm();
    for (int i = 1; i <= 20; i++) hit_cyc(1'b1, 32'h5000_0000, 32'(i));
    chk("wrap_ovf", 64'(overflow_o), 64'd1);
    chk("wrap_irq_pulses", 64'(irq_seen), 64'd1);
    chk("wrap_state", 64'(state_o), 64'd1);
    rd_en_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("wrap_pop_dat", 64'(rd_dat_o), 64'(5 + i));
    end
    rd_en_i = 1'b0;
    tick();

    // Address filter and read capture
    do_clear();
    wrap_i      = 1'b0;
    filt_base_i = 32'h3000_0000;
    filt_mask_i = 32'hffff_0000;
    pulse_arm();
    hit_cyc(1'b1, 32'h3000_0010, 32'haaaa_0001);
    hit_cyc(1'b1, 32'h2000_0010, 32'haaaa_0002);
    hit_cyc(1'b0, 32'h3000_0020, 32'hbbbb_0003);
    chk("filt_count", 64'(count_o), 64'd2);
    rd_en_i = 1'b1;
    tick();
    chk("filt_adr0", 64'(rd_adr_o), 64'h3000_0010);
    tick();
    chk("filt_rd_we", 64'(rd_we_o), 64'd0);
    chk("filt_rd_dat", 64'(rd_dat_o), 64'hbbbb_0003);
    rd_en_i = 1'b0;
    tick();

    // Full in wrap mode with simultaneous hit and pop, then pop when empty
    do_clear();
    filt_mask_i = '0;
    wrap_i      = 1'b1;
    pulse_arm();
    for (int i = 0; i < 16; i++) hit_cyc(1'b1, 32'h6000_0000, 32'(100 + i));
    bus(1'b1, 1'b1, 32'h6000_0004, 32'd999, '0);
    rd_en_i = 1'b1;
    tick();
    bus(1'b0, 1'b0, '0, '0, '0);
    chk("hitpop_count", 64'(count_o), 64'd16);
    chk("hitpop_ovf", 64'(overflow_o), 64'd0);
    chk("hitpop_dat", 64'(rd_dat_o), 64'd100);
    repeat (16) tick();
    tick();
    chk("empty_pop_valid", 64'(rd_valid_o), 64'd0);
    rd_en_i = 1'b0;

    // Asynchronous reset mid-capture, then clear beats arm
    wrap_i = 1'b0;
    for (int i = 0; i < 3; i++) hit_cyc(1'b1, 32'h7000_0000, 32'(i));
    rd_en_i = 1'b1;
    tick();
    rd_en_i = 1'b0;
    #2 wb_rst_i = 1'b1;
    #1;
    chk("arst_state", 64'(state_o), 64'd0);
    chk("arst_count", 64'(count_o), 64'd0);
    chk("arst_flags", 64'({rd_valid_o, rd_we_o, overflow_o, irq_o}), 64'd0);
    chk("arst_rd_fields", {rd_adr_o, rd_dat_o}, 64'd0);
    model_reset();
    @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    arm_i   = 1'b1;
    clear_i = 1'b1;
    tick();
    arm_i   = 1'b0;
    clear_i = 1'b0;
    chk("clear_over_arm", 64'(state_o), 64'd0);

    // Random traffic against the model
    for (int n = 0; n < 500; n++) begin
      bus($urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
          ($urandom_range(0, 1) == 1 ? 32'h3000_0000 : 32'h2000_0000) + 32'(4 * $urandom_range(0, 7)),
          $urandom, $urandom);
      case ($urandom_range(0, 2))
        0:       filt_mask_i = '0;
        1:       filt_mask_i = 32'hffff_0000;
        default: filt_mask_i = 32'hffff_fff0;
      endcase
      filt_base_i = 32'h3000_0000;
      rd_en_i = $urandom_range(0, 99) < 30;
      arm_i   = $urandom_range(0, 99) < 10;
      clear_i = $urandom_range(0, 99) < 2;
      if ($urandom_range(0, 99) < 5) wrap_i = ~wrap_i;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
